// File: rtl/float2int_seq_pkg.sv
// Shared definitions for the mini-float to integer decoder.
//   EW_DEF/MW_DEF/IW_DEF : default exponent, mantissa and integer widths
//   state_t              : controller states (IDLE, SHIFT, HOLD)
//   f2i_decode()         : combinational decode of one {E,M} code at the
//                          default widths; handy as a reference value
package float2int_seq_pkg;

  localparam int EW_DEF = 3;
  localparam int MW_DEF = 4;
  localparam int IW_DEF = 11;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    HOLD  = 2'd2
  } state_t;

  // E==0 codes are plain integers 0..15; otherwise the hidden one is
  // restored and the significand shifted up by E-1.
  function automatic logic [IW_DEF-1:0] f2i_decode(input logic [EW_DEF-1:0] e,
                                                   input logic [MW_DEF-1:0] m);
    logic [IW_DEF-1:0] v;
    if (e == '0) begin
      v = IW_DEF'(m);
    end else begin
      v = IW_DEF'({1'b1, m}) << (e - EW_DEF'(1));
    end
    return v;
  endfunction

endpackage

// File: rtl/float2int_seq_if.sv
// Handshake bundle between a float-code source, the decoder and an integer
// consumer.
//   in_valid/in_ready/in_e/in_m      : float code input channel
//   out_valid/out_ready/out_int      : decoded integer output channel
//   master modport : the environment (drives codes, accepts results)
//   slave  modport : the decoder
interface float2int_seq_if #(
  parameter int EW = 3,
  parameter int MW = 4,
  parameter int IW = 11
);
  logic          in_valid;
  logic          in_ready;
  logic [EW-1:0] in_e;
  logic [MW-1:0] in_m;
  logic          out_valid;
  logic          out_ready;
  logic [IW-1:0] out_int;

  modport master (
    output in_valid, in_e, in_m, out_ready,
    input  in_ready, out_valid, out_int
  );

  modport slave (
    input  in_valid, in_e, in_m, out_ready,
    output in_ready, out_valid, out_int
  );
endinterface

// File: rtl/float2int_seq_f2i_unpack.sv
// f2i_unpack: combinational field unpack for the decoder.
//   e_i, m_i : exponent and mantissa fields of the incoming code
//   acc_o    : starting significand (hidden one restored when E != 0)
//   cnt_o    : number of left shifts still required (E-1, or 0 for E==0)
module f2i_unpack #(
  parameter int EW = 3,
  parameter int MW = 4,
  parameter int IW = 11
) (
  input  logic [EW-1:0] e_i,
  input  logic [MW-1:0] m_i,
  output logic [IW-1:0] acc_o,
  output logic [EW-1:0] cnt_o
);

  always_comb begin
    acc_o = IW'(m_i);
    cnt_o = '0;
    if (e_i != '0) begin
      acc_o = IW'({1'b1, m_i});
      cnt_o = e_i - EW'(1);
    end
  end

endmodule

// File: rtl/float2int_seq.sv
// float2int_seq: sequential decoder from the 7-bit mini-float code
// (EW-bit exponent, MW-bit mantissa) to an IW-bit unsigned integer.
// The significand is shifted left one position per cycle until the
// exponent is consumed, then held until the consumer takes it.
//   clk, rst : rising-edge clock, asynchronous active-high reset
//   bus      : slave side of float2int_seq_if (input code channel and
//              decoded integer channel, both valid/ready)
// IW must be at least MW+1+(2^EW-2) so the largest code does not overflow.
module float2int_seq
  import float2int_seq_pkg::*;
#(
  parameter int EW = EW_DEF,
  parameter int MW = MW_DEF,
  parameter int IW = IW_DEF
) (
  input  logic           clk,
  input  logic           rst,
  float2int_seq_if.slave bus
);

  state_t        state_q, state_d;
  logic [IW-1:0] acc_q, acc_d;
  logic [EW-1:0] cnt_q, cnt_d;

  logic [IW-1:0] init_acc;
  logic [EW-1:0] init_cnt;

  f2i_unpack #(
    .EW(EW),
    .MW(MW),
    .IW(IW)
  ) u_unpack (
    .e_i  (bus.in_e),
    .m_i  (bus.in_m),
    .acc_o(init_acc),
    .cnt_o(init_cnt)
  );

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        // in_ready is high throughout IDLE, so in_valid alone is acceptance.
        if (bus.in_valid) begin
          acc_d   = init_acc;
          cnt_d   = init_cnt;
          state_d = (init_cnt == '0) ? HOLD : SHIFT;
        end
      end
      SHIFT: begin
        acc_d = acc_q << 1;
        cnt_d = cnt_q - EW'(1);
        if (cnt_q == EW'(1)) begin
          state_d = HOLD;
        end
      end
      HOLD: begin
        if (bus.out_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      acc_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
    end
  end

  // Handshake flags decode the state register only; out_ready never reaches
  // in_ready combinationally. The result is gated so idle cycles read zero.
  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = (state_q == HOLD);
  assign bus.out_int   = (state_q == HOLD) ? acc_q : '0;

endmodule

// File: tb/tb_float2int_seq.sv
// Self-checking bench for float2int_seq: directed latency/backpressure/reset
// cases, then all 128 codes in shuffled order with random handshake gaps,
// including an integer-to-float round trip on every result.
module tb_float2int_seq;
  import float2int_seq_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_mis = 0;

  always #5 clk = ~clk;

  float2int_seq_if #(.EW(3), .MW(4), .IW(11)) bus ();

  float2int_seq #(.EW(3), .MW(4), .IW(11)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, obs, obs, exp, exp);
    end
  endtask

  // Reference value straight from the format definition.
  function automatic int ref_val(input int e, input int m);
    if (e == 0) return m;
    return (16 + m) * (1 << (e - 1));
  endfunction

  // Forward integer-to-float conversion (truncating), returns {E,M}.
  function automatic int int2float(input int v);
    int p;
    if (v < 16) return v;
    p = 4;
    while ((v >> (p + 1)) != 0) p++;
    return ((p - 3) << 4) | ((v >> (p - 4)) & 15);
  endfunction

  function automatic int ref_lat(input int e);
    return (e <= 1) ? 1 : e;
  endfunction

  // One directed transfer: latency, busy in_ready, value, hold stability,
  // return to IDLE after one handshake.
  task automatic xfer(input int e, input int m, input int hold, input string tag);
    int lat;
    @(posedge clk); #1;
    chk({tag, "_rdy_idle"}, 32'(bus.in_ready), 1);
    bus.in_valid = 1'b1;
    bus.in_e = 3'(e);
    bus.in_m = 4'(m);
    bus.out_ready = 1'b0;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    bus.in_e = 3'($urandom);
    bus.in_m = 4'($urandom);
    lat = 1;
    while (!bus.out_valid && lat < 20) begin
      chk({tag, "_rdy_busy"}, 32'(bus.in_ready), 0);
      chk({tag, "_gate_busy"}, 32'(bus.out_int), 0);
      @(posedge clk); #1;
      lat++;
    end
    chk({tag, "_latency"}, 32'(lat), 32'(ref_lat(e)));
    chk({tag, "_value"}, 32'(bus.out_int), 32'(ref_val(e, m)));
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      chk({tag, "_hold_vld"}, 32'(bus.out_valid), 1);
      chk({tag, "_hold_val"}, 32'(bus.out_int), 32'(ref_val(e, m)));
      chk({tag, "_hold_rdy"}, 32'(bus.in_ready), 0);
    end
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    chk({tag, "_done_vld"}, 32'(bus.out_valid), 0);
    chk({tag, "_done_int"}, 32'(bus.out_int), 0);
    chk({tag, "_done_rdy"}, 32'(bus.in_ready), 1);
  endtask

  initial begin
    int codes[128];
    int sent_q[$];
    int rcv, idx, c, j, tmp, seen;
    bit took;

    bus.in_valid = 1'b0;
    bus.in_e = '0;
    bus.in_m = '0;
    bus.out_ready = 1'b0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", 32'(bus.out_valid), 0);
    chk("rst_out_int", 32'(bus.out_int), 0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("rst_in_ready", 32'(bus.in_ready), 1);

    // Package decode function against the format definition
    for (int k = 0; k < 128; k++) begin
      chk("pkg_decode", 32'(f2i_decode(3'(k >> 4), 4'(k & 15))), 32'(ref_val(k >> 4, k & 15)));
    end

    // Directed cases
    xfer(0, 9, 0, "e0m9");
    xfer(0, 0, 0, "e0m0");
    xfer(1, 0, 0, "e1m0");
    xfer(7, 15, 0, "e7m15");
    xfer(4, 5, 5, "bp_e4m5");
    xfer(2, 3, 1, "e2m3");

    // Reset in the middle of a SHIFT
    @(posedge clk); #1;
    bus.in_valid = 1'b1; bus.in_e = 3'd6; bus.in_m = 4'd10;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk("rst_shift_vld", 32'(bus.out_valid), 0);
    chk("rst_shift_int", 32'(bus.out_int), 0);
    @(negedge clk);
    rst = 1'b0;
    bus.out_ready = 1'b1;
    seen = 0;
    repeat (10) begin
      @(posedge clk); #1;
      if (bus.out_valid) seen++;
    end
    chk("rst_shift_no_out", 32'(seen), 0);
    chk("rst_shift_rdy", 32'(bus.in_ready), 1);
    bus.out_ready = 1'b0;

    // Reset while a result is held
    @(posedge clk); #1;
    bus.in_valid = 1'b1; bus.in_e = 3'd3; bus.in_m = 4'd7;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    chk("pre_rst_hold_vld", 32'(bus.out_valid), 1);
    chk("pre_rst_hold_int", 32'(bus.out_int), 32'(ref_val(3, 7)));
    rst = 1'b1;
    #1;
    chk("rst_hold_vld", 32'(bus.out_valid), 0);
    chk("rst_hold_int", 32'(bus.out_int), 0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("rst_hold_rdy", 32'(bus.in_ready), 1);

    // Exhaustive sweep, shuffled order, random gaps on both sides
    for (int k = 0; k < 128; k++) codes[k] = k;
    for (int k = 127; k > 0; k--) begin
      j = $urandom_range(0, k);
      tmp = codes[k]; codes[k] = codes[j]; codes[j] = tmp;
    end
    rcv = 0; idx = 0; took = 1'b0;
    for (int cyc = 0; cyc < 6000 && rcv < 128; cyc++) begin
      @(negedge clk);
      if (!bus.out_valid) chk("sweep_gate", 32'(bus.out_int), 0);
      bus.out_ready = ($urandom_range(0, 2) != 0);
      if (bus.out_valid && bus.out_ready) begin
        if (sent_q.size() == 0) begin
          chk("sweep_spurious", 1, 0);
        end else begin
          c = sent_q.pop_front();
          chk("sweep_value", 32'(bus.out_int), 32'(ref_val(c >> 4, c & 15)));
          chk("sweep_roundtrip", 32'(int2float(int'(bus.out_int))), 32'(c));
        end
        rcv++;
      end
      if (took) bus.in_valid = 1'b0;
      if (!bus.in_valid && idx < 128 && $urandom_range(0, 2) != 0) begin
        bus.in_valid = 1'b1;
        bus.in_e = 3'(codes[idx] >> 4);
        bus.in_m = 4'(codes[idx] & 15);
      end
      took = bus.in_valid && bus.in_ready;
      if (took) begin
        sent_q.push_back(codes[idx]);
        idx++;
      end
    end
    chk("sweep_count", 32'(rcv), 128);
    chk("sweep_leftover", 32'(sent_q.size()), 0);
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    seen = 0;
    repeat (12) begin
      @(negedge clk);
      if (bus.out_valid) seen++;
    end
    chk("sweep_no_extra", 32'(seen), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule

// File: doc/float2int_seq.md
# float2int_seq

Sequential decoder for the team's 7-bit mini-float format (3-bit exponent, 4-bit mantissa). It expands a float code back into the 11-bit unsigned integer it represents, i.e. the inverse of the integer-to-float conversion. The mantissa is left-shifted one bit position per cycle. Valid/ready handshakes sit on both sides, so the block can be placed between a float-coded source and integer datapath logic.

## Interface
- EW, 3, exponent width
- MW, 4, mantissa width (hidden leading one not stored)
- IW, 11, integer output width; must satisfy IW >= MW+1+(2^EW-2)
- clk  in  1  single clock, rising edge
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  float code present
- in_ready  out  1  block can accept a code
- in_e  in  EW  exponent field (E2..E0)
- in_m  in  MW  mantissa field (M3..M0)
- out_valid  out  1  integer result present
- out_ready  in  1  consumer accepts result
- out_int  out  IW  decoded integer (B10..B0)

## Operation
- Format decision:
  - E==0 → value = M (0..15).
  - E>=1 → value = {1,M} << (E-1), covering 16..1984.
  - Low bits lost by truncation in the forward direction decode as zero.
- FSM states: IDLE, SHIFT, HOLD.
- IDLE:
  - in_ready=1.
  - On in_valid&in_ready, load acc = zero-extended M if E==0, else zero-extended {1,M}.
  - Load cnt = (E==0) ? 0 : E-1.
  - Next state: HOLD if cnt==0, else SHIFT.
- SHIFT:
  - in_ready=0. Each cycle acc <= acc<<1 and cnt <= cnt-1.
  - The cycle in which cnt goes 1→0 moves to HOLD.
- HOLD:
  - out_valid=1 and out_int=acc.
  - On out_ready, move to IDLE.
  - in_ready stays 0 in HOLD; there is no same-cycle re-accept.
- out_int is 0 whenever out_valid=0. The output is gated, so no stale values are visible.
- in_e/in_m are sampled only at acceptance. Changes while busy are ignored.
- No error states exist: every one of the 128 codes is legal.
- Reset:
  - rst=1 at any time forces IDLE, acc=0, cnt=0, out_valid=0, out_int=0 and in_ready=1 (after reset release).
  - A transfer in flight is discarded and produces no output.

## Timing
- Acceptance in cycle t → out_valid rises in cycle t+1+cnt, where cnt = max(E-1,0).
  - E=0 or 1: latency 1.
  - E=7: latency 7.
- Result held stable (out_valid, out_int) until the cycle out_ready=1. IDLE is entered the following cycle.
- Minimum initiation interval is latency+1 cycles with out_ready tied high. For E=0 this is 2 cycles.
- in_ready is a registered state decode, with no combinational path from out_ready.
- Reset values: in_ready=1 once released, out_valid=0, out_int=0.

## Structure
- Shared package holds:
  - EW/MW/IW defaults.
  - The state enum (IDLE/SHIFT/HOLD).
  - A function computing the decoded value combinationally, used by the bench as the golden model.
- One sub-module is natural: f2i_unpack, combinational. Inputs E,M; outputs the initial acc and cnt. Keeps the FSM/shift logic in float2int_seq separate.
- acc width IW, cnt width EW.

## Test plan
- E=0,M=9 accepted at t → out_valid at t+1, out_int=9. E=0,M=0 → out_int=0.
- E=1,M=0 → 16 at latency 1. E=7,M=15 → 1984 (0x7C0) at latency 7. in_ready=0 throughout.
- Backpressure: E=4,M=5 (→168), out_ready low 5 cycles → out_valid and out_int=168 stable, in_ready=0, then one handshake → IDLE.
- Reset asserted mid-SHIFT of E=6 → out_valid=0 and out_int=0 immediately. No result appears afterward. in_ready=1 after release.
- Exhaustive sweep of all 128 codes with random in_valid/out_ready gaps → every out_int matches the package function, in order, with no drops or duplicates.
- Round trip: each decoded out_int fed through the integer-to-float converter reproduces the original {E,M} for all 128 codes.
